cksum_tx: RTL and testbench

CKSUM_TX -- requirements
Module: cksum_tx

---
 rtl/cksum_pkg.sv | 21 ++
 rtl/word_serializer.sv | 38 +++
 rtl/cksum_tx.sv | 150 +++++++++++++++
 tb/tb_cksum_tx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cksum_pkg.sv
// Shared types and helpers for the header checksum transmitter.
// Holds the FSM state encoding, default frame geometry and the ones-complement adder.
package cksum_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FOLD = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam int DEF_HDR_WORDS = 10;
    localparam int DEF_CK_IDX    = 5;

    // The carry out of the 17-bit sum wraps into bit 0; the result can never carry again.
    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/word_serializer.sv
// Loads one 16-bit word and shifts it out N bits per cycle, MSB-first.
// o_last flags the final chunk of the currently loaded word.
module word_serializer #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [15:0]  i_word,
    input  logic         i_shift,
    output logic [N-1:0] o_chunk,
    output logic         o_last
);

    localparam int CHUNKS = 16 / N;
    localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    logic [15:0]      r_shreg;
    logic [CNT_W-1:0] r_cnt;

    // A load restarts the chunk counter; it wins over a shift in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shreg <= i_word;
            r_cnt   <= '0;
        end else if (i_shift) begin
            r_shreg <= r_shreg << N;
            r_cnt   <= o_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign o_chunk = r_shreg[15 -: N];
    assign o_last  = (r_cnt == CNT_W'(CHUNKS - 1));

endmodule

// File: rtl/cksum_tx.sv
// Buffers a header, computes its ones-complement checksum and transmits it N bits per cycle.
// Optional feature: define CKSUM_TX_STATS_EN to add the frame_cnt completed-frame counter.
module cksum_tx
    import cksum_pkg::*;
#(
    parameter int N         = 2,
    parameter int HDR_WORDS = DEF_HDR_WORDS,
    parameter int CK_IDX    = DEF_CK_IDX
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         axiiv,
    input  logic [15:0]  axiid,
    output logic         axiov,
    output logic [N-1:0] axiod,
    output logic         busy
`ifdef CKSUM_TX_STATS_EN
    ,
    output logic [15:0]  frame_cnt
`endif
);

    localparam int IDX_W = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;

    state_t           r_state;
    state_t           w_next_state;
    logic [IDX_W-1:0] r_wcnt;
    logic [IDX_W-1:0] r_widx;
    logic [IDX_W-1:0] w_next_widx;
    logic [15:0]      r_sum;
    logic [15:0]      r_cksum;
    logic [15:0]      r_buf [HDR_WORDS];

    logic             w_accept;
    logic             w_last_word_in;
    logic [15:0]      w_addend;
    logic             w_ser_last;
    logic             w_word_done;
    logic             w_frame_done;
    logic             w_ser_load;
    logic [15:0]      w_first_word;
    logic [15:0]      w_ser_word;
    logic [N-1:0]     w_chunk;

    assign w_accept       = (r_state == LOAD) && axiiv;
    assign w_last_word_in = w_accept && (r_wcnt == IDX_W'(HDR_WORDS - 1));
    assign w_addend       = (r_wcnt == IDX_W'(CK_IDX)) ? 16'h0000 : axiid;
    assign w_word_done    = (r_state == SEND) && w_ser_last;
    assign w_frame_done   = w_word_done && (r_widx == IDX_W'(HDR_WORDS - 1));
    assign w_next_widx    = r_widx + IDX_W'(1);

    // Word 0 is loaded during FOLD, before the checksum register exists.
    assign w_first_word = (CK_IDX == 0) ? ~r_sum : r_buf[0];
    assign w_ser_load   = (r_state == FOLD) || (w_word_done && !w_frame_done);
    assign w_ser_word   = (r_state == FOLD) ? w_first_word :
                          (w_next_widx == IDX_W'(CK_IDX)) ? r_cksum : r_buf[w_next_widx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            LOAD:    if (w_last_word_in) w_next_state = FOLD;
            FOLD:    w_next_state = SEND;
            SEND:    if (w_frame_done) w_next_state = LOAD;
            default: w_next_state = LOAD;
        endcase
    end

    always_comb begin
        axiov = 1'b0;
        axiod = '0;
        busy  = 1'b0;
        if (r_state == SEND) begin
            axiov = 1'b1;
            axiod = w_chunk;
            busy  = 1'b1;
        end else if (r_state == FOLD) begin
            busy = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt  <= '0;
            r_widx  <= '0;
            r_sum   <= '0;
            r_cksum <= '0;
        end else begin
            if (w_accept) begin
                r_wcnt <= r_wcnt + IDX_W'(1);
                r_sum  <= ones_add(r_sum, w_addend);
            end
            if (r_state == FOLD) begin
                r_cksum <= ~r_sum;
                r_widx  <= '0;
            end
            if (w_word_done) begin
                r_widx <= w_next_widx;
            end
            if (w_frame_done) begin
                r_wcnt <= '0;
                r_widx <= '0;
                r_sum  <= '0;
            end
        end
    end

    // Header storage needs no reset: every slot is rewritten before it is sent.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_wcnt] <= axiid;
        end else if (r_state == FOLD) begin
            r_buf[CK_IDX] <= ~r_sum;
        end
    end

    word_serializer #(
        .N(N)
    ) u_ser (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_ser_load),
        .i_word  (w_ser_word),
        .i_shift (r_state == SEND),
        .o_chunk (w_chunk),
        .o_last  (w_ser_last)
    );

`ifdef CKSUM_TX_STATS_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (w_frame_done) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_cksum_tx.sv
// Directed bench for cksum_tx: known headers with hand-computed checksums, gaps, resets and ignored input.
// Build with CKSUM_TX_STATS_EN defined to also check frame_cnt.
module tb_cksum_tx;

    localparam int N         = 2;
    localparam int HDR_WORDS = 10;
    localparam int CK_IDX    = 5;
    localparam int CHUNKS    = HDR_WORDS * 16 / N;

    logic           clk = 1'b0;
    logic           rst;
    logic           axiiv;
    logic [15:0]    axiid;
    logic           axiov;
    logic [N-1:0]   axiod;
    logic           busy;
`ifdef CKSUM_TX_STATS_EN
    logic [15:0]    frame_cnt;
`endif

    int compareCount  = 0;
    int mismatchCount = 0;
    int expFrames     = 0;

    logic [15:0]             txWords [HDR_WORDS];
    logic [16*HDR_WORDS-1:0] rxBits;

    cksum_tx #(
        .N(N),
        .HDR_WORDS(HDR_WORDS),
        .CK_IDX(CK_IDX)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .axiiv (axiiv),
        .axiid (axiid),
        .axiov (axiov),
        .axiod (axiod),
        .busy  (busy)
`ifdef CKSUM_TX_STATS_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic driveIdle(input bit junk);
        if (junk) begin
            axiiv = 1'b1;
            axiid = 16'($urandom);
        end else begin
            axiiv = 1'b0;
            axiid = 16'hDEAD;
        end
    endtask

    // Drives txWords; inputs change on negedges so the DUT samples them mid-cycle.
    task automatic applyStimulus(input int gap);
        for (int i = 0; i < HDR_WORDS; i++) begin
            @(negedge clk);
            axiiv = 1'b1;
            axiid = txWords[i];
            if (i < HDR_WORDS - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    driveIdle(1'b0);
                end
            end
        end
    endtask

    // Called right after the last word was driven; checks latency, length and content.
    task automatic receiveFrame(input string name, input logic [15:0] expCk, input bit junk);
        int cnt;
        logic [15:0] expWord;
        @(negedge clk);
        driveIdle(junk);
        checkOutput({name, ".foldValid"}, 32'(axiov), 32'd0);
        checkOutput({name, ".foldBusy"}, 32'(busy), 32'd1);
        @(negedge clk);
        driveIdle(junk);
        checkOutput({name, ".firstChunk"}, 32'(axiov), 32'd1);
        checkOutput({name, ".sendBusy"}, 32'(busy), 32'd1);
        cnt    = 0;
        rxBits = '0;
        while (axiov === 1'b1 && cnt < 200) begin
            rxBits = {rxBits[16*HDR_WORDS-N-1:0], axiod};
            cnt++;
            @(negedge clk);
            driveIdle(junk);
        end
        driveIdle(1'b0);
        checkOutput({name, ".validCycles"}, 32'(cnt), 32'(CHUNKS));
        checkOutput({name, ".idleBusy"}, 32'(busy), 32'd0);
        checkOutput({name, ".idleData"}, 32'(axiod), 32'd0);
        expFrames++;
`ifdef CKSUM_TX_STATS_EN
        checkOutput({name, ".frameCnt"}, 32'(frame_cnt), 32'(expFrames));
`endif
        for (int i = 0; i < HDR_WORDS; i++) begin
            expWord = (i == CK_IDX) ? expCk : txWords[i];
            checkOutput($sformatf("%s.word%0d", name, i), 32'(rxBits[16*(HDR_WORDS-1-i) +: 16]), 32'(expWord));
        end
    endtask

    task automatic setIpv4();
        txWords = '{16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011,
                    16'hFFFF, 16'hC0A8, 16'h0001, 16'hC0A8, 16'h00C7};
    endtask

    task automatic setZero();
        for (int i = 0; i < HDR_WORDS; i++) txWords[i] = 16'h0000;
    endtask

    // 1000+2000+3000+4000+5000+0F00+00F0+000F = FFFF with no carry; word 5 is ignored.
    task automatic setSumFfff();
        txWords = '{16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h5000,
                    16'hABCD, 16'h0F00, 16'h00F0, 16'h000F, 16'h0000};
    endtask

    task automatic setAllOnes();
        for (int i = 0; i < HDR_WORDS; i++) txWords[i] = 16'hFFFF;
        txWords[CK_IDX] = 16'h0000;
    endtask

    initial begin
        rst   = 1'b1;
        axiiv = 1'b0;
        axiid = 16'h0000;
        repeat (2) @(negedge clk);
        checkOutput("reset.valid", 32'(axiov), 32'd0);
        checkOutput("reset.data", 32'(axiod), 32'd0);
        checkOutput("reset.busy", 32'(busy), 32'd0);
`ifdef CKSUM_TX_STATS_EN
        checkOutput("reset.frameCnt", 32'(frame_cnt), 32'd0);
`endif
        rst = 1'b0;

        setIpv4();
        applyStimulus(0);
        receiveFrame("ipv4", 16'hB861, 1'b0);

        applyStimulus(2);
        receiveFrame("ipv4Gap", 16'hB861, 1'b0);

        setZero();
        applyStimulus(0);
        receiveFrame("zero", 16'hFFFF, 1'b0);

        setSumFfff();
        applyStimulus(1);
        receiveFrame("sumFfff", 16'h0000, 1'b0);

        setAllOnes();
        applyStimulus(0);
        receiveFrame("allOnes", 16'h0000, 1'b0);

        setIpv4();
        applyStimulus(0);
        receiveFrame("junkDuringSend", 16'hB861, 1'b1);
        setSumFfff();
        applyStimulus(0);
        receiveFrame("afterJunk", 16'h0000, 1'b0);

        setIpv4();
        applyStimulus(0);
        @(negedge clk);
        driveIdle(1'b0);
        repeat (31) @(negedge clk);
        checkOutput("midSend.preReset", 32'(axiov), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("midSend.valid", 32'(axiov), 32'd0);
        checkOutput("midSend.data", 32'(axiod), 32'd0);
        checkOutput("midSend.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        expFrames = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput($sformatf("midSend.noResume%0d", c), 32'(axiov), 32'd0);
        end
        applyStimulus(0);
        receiveFrame("afterSendReset", 16'hB861, 1'b0);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            axiiv = 1'b1;
            axiid = 16'h1234 + 16'(i);
        end
        @(negedge clk);
        driveIdle(1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        expFrames = 0;
        setZero();
        applyStimulus(0);
        receiveFrame("afterLoadReset", 16'hFFFF, 1'b0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
